// File: rtl/multicycle_seq.sv
// -----------------------------------------------------------------------------
// multicycle_seq
//   Multi-cycle sequencer for the miniRV datapath. Steps each instruction
//   through BOOT/FETCH/DECODE/EXEC/MEM/WB. It handshakes with the instruction
//   and data memories and gates the static decoder's rf_we/ram_we so that the
//   architectural state is written exactly once per instruction. A memory that
//   stays unready too long, or an unknown opcode, parks the core in TRAP
//   until the next reset.
//
//   Parameters
//     TIMEOUT      cycles to wait for imem_ready/dmem_ready before trapping (1..255)
//     BOOT_CYCLES  cycles held in BOOT after reset release (1..15)
//
//   Ports
//     cpu_clk, cpu_rst      core clock, asynchronous active-high reset
//     opcode                inst[6:0] from the IR register
//     imem_ready            instruction memory has data; IR loads this cycle
//     dmem_ready            data memory access complete
//     dec_rf_we/dec_ram_we  ungated write enables from the decode controller
//     imem_req/dmem_req     memory requests
//     ir_we, pc_we          IR load strobe, PC update strobe
//     rf_we, ram_we         gated architectural write enables
//     state                 current state (debug)
//     trap, trap_cause      sticky fault flag; 0 none, 1 illegal opcode,
//                           2 imem timeout, 3 dmem timeout
//
//   Optional feature (macro MULTICYCLE_PERF_EN)
//     Adds cycle_cnt (cycles outside BOOT/TRAP) and instret_cnt (pc_we
//     pulses). Both are 32 bits, reset to 0 and wrap.
// -----------------------------------------------------------------------------
module multicycle_seq #(
    parameter int unsigned TIMEOUT     = 16,
    parameter int unsigned BOOT_CYCLES = 1
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [6:0]  opcode,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        dec_rf_we,
    input  logic        dec_ram_we,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic        ram_we,
    output logic [2:0]  state,
    output logic        trap,
    output logic [1:0]  trap_cause
`ifdef MULTICYCLE_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_I, C_LW, C_SW, C_B, C_LUI, C_JAL, C_JALR
    } iclass_t;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

    // Last wait-counter value before the limit; a ready seen on that cycle
    // still wins over the timeout.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] BOOT_LAST    = 8'(BOOT_CYCLES - 1);

    state_t     state_q, state_d;
    iclass_t    cls_q, cls_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] cause_q, cause_d;

    iclass_t    dec_cls;
    logic       dec_legal;

    // Opcode classification; only consumed in DECODE.
    always_comb begin
        dec_cls   = C_R;
        dec_legal = 1'b1;
        unique case (opcode)
            7'b0110011: dec_cls = C_R;
            7'b0010011: dec_cls = C_I;
            7'b0000011: dec_cls = C_LW;
            7'b0100011: dec_cls = C_SW;
            7'b1100011: dec_cls = C_B;
            7'b0110111: dec_cls = C_LUI;
            7'b1101111: dec_cls = C_JAL;
            7'b1100111: dec_cls = C_JALR;
            default:    dec_legal = 1'b0;
        endcase
    end

    // Next state and strobes.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        cls_d    = cls_q;
        cause_d  = cause_q;
        cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;  // saturating
        imem_req = 1'b0;
        dmem_req = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        rf_we    = 1'b0;
        ram_we   = 1'b0;

        unique case (state_q)
            S_BOOT: begin
                if (cnt_q >= BOOT_LAST) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_IMEM_TO;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    cls_d   = dec_cls;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                if (cls_q == C_B) begin
                    pc_we   = 1'b1;   // branch retires here
                    state_d = S_FETCH;
                end else if (cls_q == C_LW || cls_q == C_SW) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                ram_we   = dec_ram_we & (cls_q == C_SW);
                if (dmem_ready) begin
                    if (cls_q == C_SW) begin
                        pc_we   = 1'b1;   // store retires on completion
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_DMEM_TO;
                end
            end
            S_WB: begin
                rf_we   = dec_rf_we;
                pc_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                // Unused encoding: park safely.
                state_d = S_TRAP;
            end
        endcase

        if (state_d != state_q) cnt_d = 8'd0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from the same clock edge.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q <= S_BOOT;
            cls_q   <= C_R;
            cnt_q   <= 8'd0;
            cause_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    assign state      = state_q;
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;

`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (state_q != S_BOOT && state_q != S_TRAP) cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (pc_we) instret_cnt_d = instret_cnt_q + 32'd1;
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            cycle_cnt_q   <= 32'd0;
            instret_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule
